// File: rtl/oram_access_ctrl.sv
// oram_access_ctrl: sequences one tree-ORAM access.
// Each access runs the same fixed state sequence: position-map lookup, a
// read-and-remove pass over the whole path, root insertion under a fresh
// random leaf, then a flush of one random path. Hit and miss take the same
// number of cycles, so the RAM traffic pattern does not depend on the data.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. rsp_valid is a
// single-cycle pulse with no backpressure. rsp_rdata/rsp_hit hold their
// value until the next response.
module oram_access_ctrl #(
  parameter int          BYTE_WIDTH      = 8,
  parameter int          BYTES_PER_BLOCK = 4,
  parameter int          TREE_DEPTH      = 2,
  parameter int          K               = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                                                  clk,
  input  logic                                                                  rst_n,
  input  logic                                                                  req_valid,
  output logic                                                                  req_ready,
  input  logic                                                                  req_write,
  input  logic [TREE_DEPTH-1:0]                                                 req_block,
  input  logic [BYTE_WIDTH*BYTES_PER_BLOCK-1:0]                                 req_wdata,
  output logic                                                                  rsp_valid,
  output logic [BYTE_WIDTH*BYTES_PER_BLOCK-1:0]                                 rsp_rdata,
  output logic                                                                  rsp_hit,
  output logic                                                                  bkt_rd_en,
  output logic                                                                  bkt_wr_en,
  output logic [TREE_DEPTH-1:0]                                                 bkt_addr,
  output logic [K*(1+TREE_DEPTH+(TREE_DEPTH-1)+BYTE_WIDTH*BYTES_PER_BLOCK)-1:0] bkt_wr_data,
  input  logic [K*(1+TREE_DEPTH+(TREE_DEPTH-1)+BYTE_WIDTH*BYTES_PER_BLOCK)-1:0] bkt_rd_data,
  output logic                                                                  err_overflow,
  output logic [3:0]                                                            fsm_state
);

  localparam int BW  = BYTE_WIDTH * BYTES_PER_BLOCK;
  localparam int LB  = TREE_DEPTH - 1;
  localparam int TW  = 1 + TREE_DEPTH + LB + BW;
  localparam int BKW = K * TW;
  localparam int NB  = 1 << TREE_DEPTH;
  localparam int LW  = $clog2(TREE_DEPTH);

  localparam logic [LW-1:0]         LAST_PATH  = LW'(TREE_DEPTH - 1);
  localparam logic [LW-1:0]         LAST_FLUSH = LW'(TREE_DEPTH - 2);
  localparam logic [TREE_DEPTH-1:0] ONE        = TREE_DEPTH'(1);
  localparam logic [TREE_DEPTH-1:0] ALL_ONES   = '1;

  localparam logic [3:0] INIT    = 4'd0;
  localparam logic [3:0] IDLE    = 4'd1;
  localparam logic [3:0] LOOKUP  = 4'd2;
  localparam logic [3:0] PATH_RD = 4'd3;
  localparam logic [3:0] PATH_WR = 4'd4;
  localparam logic [3:0] ROOT_RD = 4'd5;
  localparam logic [3:0] ROOT_WR = 4'd6;
  localparam logic [3:0] FL_RDP  = 4'd7;
  localparam logic [3:0] FL_RDC  = 4'd8;
  localparam logic [3:0] FL_WRC  = 4'd9;
  localparam logic [3:0] FL_WRP  = 4'd10;
  localparam logic [3:0] DONE    = 4'd11;

  logic [3:0]                 state;
  logic [TREE_DEPTH-1:0]      init_cnt;
  logic [LW-1:0]              lvl;
  logic [TREE_DEPTH-1:0]      node;      // path node, or flush parent node
  logic [TREE_DEPTH-1:0]      cur_blk;
  logic                       cur_write;
  logic [BW-1:0]              cur_wdata;
  logic [LB-1:0]              leaf;
  logic                       hit;
  logic [BW-1:0]              cap_val;
  logic [LB-1:0]              new_leaf;
  logic [LB-1:0]              pos_star;
  logic [BKW-1:0]             parent_q;
  logic [NB-1:0]              pm_valid;
  logic [NB-1:0][LB-1:0]      pm_pos;
  logic [15:0]                lfsr;

  logic [BKW-1:0]             pw_bucket;
  logic                       pw_hit;
  logic [BW-1:0]              pw_val;
  logic [BKW-1:0]             rw_bucket;
  logic                       rw_ok;
  logic [BW-1:0]              new_val;
  logic [BKW-1:0]             fl_child;
  logic [BKW-1:0]             fl_parent;
  logic [TREE_DEPTH-1:0]      cnode;
  logic [TW-1:0]              ptup;
  logic [LB-1:0]              ptup_pos;
  logic                       placed;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign fsm_state = state;

  // Path bucket: clear every tuple of the requested block on the chosen leaf.
  always_comb begin
    pw_bucket = bkt_rd_data;
    pw_hit    = 1'b0;
    pw_val    = '0;
    for (int j = 0; j < K; j++) begin
      if (bkt_rd_data[j*TW + TW-1] &&
          bkt_rd_data[j*TW + BW + LB +: TREE_DEPTH] == cur_blk &&
          bkt_rd_data[j*TW + BW +: LB] == leaf) begin
        pw_bucket[j*TW +: TW] = '0;
        pw_hit                = 1'b1;
        pw_val                = bkt_rd_data[j*TW +: BW];
      end
    end
  end

  // Root bucket: drop the remapped tuple into the lowest empty slot.
  always_comb begin
    new_val   = cur_write ? cur_wdata : cap_val;
    rw_bucket = bkt_rd_data;
    rw_ok     = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (!rw_ok && !bkt_rd_data[j*TW + TW-1]) begin
        rw_bucket[j*TW +: TW] = {1'b1, cur_blk, new_leaf, new_val};
        rw_ok                 = 1'b1;
      end
    end
  end

  // Flush step: move eligible parent tuples, lowest index first, into free child slots.
  always_comb begin
    cnode     = {node[TREE_DEPTH-2:0], pos_star[lvl]};
    fl_child  = bkt_rd_data;
    fl_parent = parent_q;
    ptup      = '0;
    ptup_pos  = '0;
    placed    = 1'b0;
    for (int i = 0; i < K; i++) begin
      ptup     = parent_q[i*TW +: TW];
      ptup_pos = ptup[BW +: LB];
      placed   = 1'b0;
      if (ptup[TW-1] && ptup_pos[lvl] == pos_star[lvl]) begin
        for (int j = 0; j < K; j++) begin
          if (!placed && !fl_child[j*TW + TW-1]) begin
            fl_child[j*TW +: TW] = ptup;
            placed               = 1'b1;
          end
        end
        if (placed) begin
          fl_parent[i*TW +: TW] = '0;
        end
      end
    end
  end

  // Bucket RAM port: at most one strobe per state; INIT writes are held off during reset.
  always_comb begin
    bkt_rd_en   = 1'b0;
    bkt_wr_en   = 1'b0;
    bkt_addr    = '0;
    bkt_wr_data = '0;
    case (state)
      INIT: begin
        if (rst_n) begin
          bkt_wr_en = 1'b1;
          bkt_addr  = init_cnt;
        end
      end
      PATH_RD: begin
        bkt_rd_en = 1'b1;
        bkt_addr  = node - ONE;
      end
      PATH_WR: begin
        bkt_wr_en   = 1'b1;
        bkt_addr    = node - ONE;
        bkt_wr_data = pw_bucket;
      end
      ROOT_RD: begin
        bkt_rd_en = 1'b1;
      end
      ROOT_WR: begin
        bkt_wr_en   = 1'b1;
        bkt_wr_data = rw_bucket;
      end
      FL_RDP: begin
        bkt_rd_en = 1'b1;
        bkt_addr  = node - ONE;
      end
      FL_RDC: begin
        bkt_rd_en = 1'b1;
        bkt_addr  = cnode - ONE;
      end
      FL_WRC: begin
        bkt_wr_en   = 1'b1;
        bkt_addr    = cnode - ONE;
        bkt_wr_data = fl_child;
      end
      FL_WRP: begin
        bkt_wr_en   = 1'b1;
        bkt_addr    = node - ONE;
        bkt_wr_data = parent_q;
      end
      default: ;
    endcase
  end

  // Access sequencer, position map, LFSR and response/error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      init_cnt     <= '0;
      lvl          <= '0;
      node         <= '0;
      cur_blk      <= '0;
      cur_write    <= 1'b0;
      cur_wdata    <= '0;
      leaf         <= '0;
      hit          <= 1'b0;
      cap_val      <= '0;
      new_leaf     <= '0;
      pos_star     <= '0;
      parent_q     <= '0;
      pm_valid     <= '0;
      pm_pos       <= '0;
      lfsr         <= LFSR_SEED;
      rsp_rdata    <= '0;
      rsp_hit      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ONE;
          if (init_cnt == ALL_ONES) state <= IDLE;
        end
        IDLE: begin
          if (req_valid) begin
            cur_blk   <= req_block;
            cur_write <= req_write;
            cur_wdata <= req_wdata;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          leaf    <= pm_valid[cur_blk] ? pm_pos[cur_blk] : lfsr[LB-1:0];
          hit     <= 1'b0;
          cap_val <= '0;
          node    <= ONE;
          lvl     <= '0;
          state   <= PATH_RD;
        end
        PATH_RD: state <= PATH_WR;
        PATH_WR: begin
          // Levels are visited root first, so the deepest match is captured last.
          if (pw_hit) begin
            hit     <= 1'b1;
            cap_val <= pw_val;
          end
          if (lvl == LAST_PATH) begin
            state <= ROOT_RD;
          end else begin
            lvl   <= lvl + LW'(1);
            node  <= {node[TREE_DEPTH-2:0], leaf[lvl]};
            state <= PATH_RD;
          end
        end
        ROOT_RD: begin
          new_leaf <= lfsr[LB-1:0];
          state    <= ROOT_WR;
        end
        ROOT_WR: begin
          if (rw_ok) begin
            pm_valid[cur_blk] <= 1'b1;
            pm_pos[cur_blk]   <= new_leaf;
          end else begin
            pm_valid[cur_blk] <= 1'b0;
            err_overflow      <= 1'b1;
          end
          pos_star <= lfsr[LB-1:0];
          node     <= ONE;
          lvl      <= '0;
          state    <= FL_RDP;
        end
        FL_RDP: state <= FL_RDC;
        FL_RDC: begin
          parent_q <= bkt_rd_data;
          state    <= FL_WRC;
        end
        FL_WRC: begin
          parent_q <= fl_parent;
          state    <= FL_WRP;
        end
        FL_WRP: begin
          if (lvl == LAST_FLUSH) begin
            rsp_rdata <= cap_val;
            rsp_hit   <= hit;
            state     <= DONE;
          end else begin
            lvl   <= lvl + LW'(1);
            node  <= cnode;
            state <= FL_RDP;
          end
        end
        DONE:    state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_oram_access_ctrl.sv
// tb_oram_access_ctrl: directed and scoreboarded checks of oram_access_ctrl
// at default parameters (depth 2, 3 tuples per bucket, 32-bit blocks).
module tb_oram_access_ctrl;

  localparam int D   = 2;
  localparam int LB  = 1;
  localparam int BW  = 32;
  localparam int K   = 3;
  localparam int TW  = 1 + D + LB + BW;
  localparam int NW  = K * TW;
  localparam int NB  = 4;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [D-1:0]  req_block = '0;
  logic [BW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [BW-1:0] rsp_rdata;
  logic          rsp_hit;
  logic          bkt_rd_en;
  logic          bkt_wr_en;
  logic [D-1:0]  bkt_addr;
  logic [NW-1:0] bkt_wr_data;
  logic [NW-1:0] bkt_rd_data;
  logic          err_overflow;
  logic [3:0]    fsm_state;

  int total = 0;
  int bad = 0;
  int conflicts = 0;
  logic [BW-1:0] exp_q[$];

  logic          preload = 1'b0;
  logic [NW-1:0] preload_word = '0;
  logic [NW-1:0] mem [NB];

  // clock
  always #5 clk = ~clk;

  oram_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_block    (req_block),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_hit      (rsp_hit),
    .bkt_rd_en    (bkt_rd_en),
    .bkt_wr_en    (bkt_wr_en),
    .bkt_addr     (bkt_addr),
    .bkt_wr_data  (bkt_wr_data),
    .bkt_rd_data  (bkt_rd_data),
    .err_overflow (err_overflow),
    .fsm_state    (fsm_state)
  );

  // bucket RAM model: one-cycle read latency, plus a backdoor fill of every word
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < NB; a++) mem[a] <= preload_word;
    end else if (bkt_wr_en) begin
      mem[bkt_addr] <= bkt_wr_data;
    end
    if (bkt_rd_en) bkt_rd_data <= mem[bkt_addr];
  end

  // RAM port strobes must never overlap
  always @(negedge clk) begin
    if (bkt_rd_en && bkt_wr_en) conflicts++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drives one request; lat_o = cycles from acceptance to rsp_valid (0 if no response arrived)
  task automatic do_access(input logic wr, input logic [D-1:0] b, input logic [BW-1:0] wd,
                           output logic hit_o, output logic [BW-1:0] rd_o,
                           output int lat_o, output int wait_o);
    wait_o = 0;
    lat_o = 0;
    hit_o = 1'b0;
    rd_o = '0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        wait_o = i;
        break;
      end
    end
    if (wait_o == 0) return;
    req_valid = 1'b1;
    req_write = wr;
    req_block = b;
    req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        lat_o = c;
        hit_o = rsp_hit;
        rd_o = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_hit, bkt_rd_en, bkt_wr_en, err_overflow} !== 6'b0 ||
        rsp_rdata !== '0 || bkt_addr !== '0 || bkt_wr_data !== '0 || fsm_state !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b vld=%b hit=%b rd=%b wr=%b err=%b rdata=%h addr=%0d state=%0d, required all 0",
               req_ready, rsp_valid, rsp_hit, bkt_rd_en, bkt_wr_en, err_overflow, rsp_rdata, bkt_addr, fsm_state);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bkt_wr_en !== 1'b1 || bkt_rd_en !== 1'b0 || bkt_addr !== D'(i) || bkt_wr_data !== '0) begin
        bad++;
        $display("FAIL init_write_%0d: wr=%b rd=%b addr=%0d data_zero=%b, required wr=1 rd=0 addr=%0d data_zero=1",
                 i, bkt_wr_en, bkt_rd_en, bkt_addr, (bkt_wr_data == '0), i);
      end
      @(negedge clk);
    end
    total++;
    if (req_ready !== 1'b1 || bkt_wr_en !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_init: ready=%b wr=%b, required ready=1 wr=0", req_ready, bkt_wr_en);
    end
  endtask

  task automatic test_write_read();
    logic h; logic [BW-1:0] r; int lat; int w;
    do_access(1'b1, 2'd2, 32'hDEADBEEF, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0) begin
      bad++;
      $display("FAIL write_blk2: lat=%0d hit=%b rdata=%h, required lat=%0d hit=0 rdata=0", lat, h, r, LAT);
    end
    do_access(1'b0, 2'd2, 32'h0, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b1 || r !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_blk2: lat=%0d hit=%b rdata=%h, required lat=%0d hit=1 rdata=deadbeef", lat, h, r, LAT);
    end
  endtask

  task automatic test_miss();
    logic h; logic [BW-1:0] r; int lat; int w;
    do_access(1'b0, 2'd1, 32'h0, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0) begin
      bad++;
      $display("FAIL miss_blk1: lat=%0d hit=%b rdata=%h, required lat=%0d hit=0 rdata=0", lat, h, r, LAT);
    end
    do_access(1'b0, 2'd1, 32'h0, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b1 || r !== 32'h0) begin
      bad++;
      $display("FAIL reread_blk1: lat=%0d hit=%b rdata=%h, required lat=%0d hit=1 rdata=0", lat, h, r, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic h; logic [BW-1:0] r; int lat; int w;
    do_access(1'b1, 2'd0, 32'h12345678, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0) begin
      bad++;
      $display("FAIL b2b_write: lat=%0d hit=%b rdata=%h, required lat=%0d hit=0 rdata=0", lat, h, r, LAT);
    end
    do_access(1'b0, 2'd0, 32'h0, h, r, lat, w);
    total++;
    if (w !== 1 || lat !== LAT || h !== 1'b1 || r !== 32'h12345678) begin
      bad++;
      $display("FAIL b2b_read: wait=%0d lat=%0d hit=%b rdata=%h, required wait=1 lat=%0d hit=1 rdata=12345678",
               w, lat, h, r, LAT);
    end
  endtask

  task automatic test_overflow();
    logic h; logic [BW-1:0] r; int lat; int w;
    logic [TW-1:0] tup;
    total++;
    if (err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL err_before: err=%b, required 0", err_overflow);
    end
    // every bucket full of block-0 tuples, so block 3 never matches and nothing can move
    for (int s = 0; s < K; s++) begin
      tup = {1'b1, 2'd0, 1'b0, 32'hF00D0000 | 32'(s)};
      preload_word[s*TW +: TW] = tup;
    end
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    do_access(1'b1, 2'd3, 32'hCAFEF00D, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0 || err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_write: lat=%0d hit=%b rdata=%h err=%b, required lat=%0d hit=0 rdata=0 err=1",
               lat, h, r, err_overflow, LAT);
    end
    total++;
    if (mem[0] !== preload_word) begin
      bad++;
      $display("FAIL overflow_root: root=%h, required unchanged %h", mem[0], preload_word);
    end
    do_access(1'b0, 2'd3, 32'h0, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0 || err_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_read: lat=%0d hit=%b rdata=%h err=%b, required lat=%0d hit=0 rdata=0 err=1",
               lat, h, r, err_overflow, LAT);
    end
  endtask

  task automatic test_mid_reset();
    logic h; logic [BW-1:0] r; int lat; int w;
    int nwr; int nrsp; bit seq_ok;
    do_reset();
    do_access(1'b1, 2'd1, 32'h55AA55AA, h, r, lat, w);
    total++;
    if (lat !== LAT || err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrst_setup: lat=%0d err=%b, required lat=%0d err=0", lat, err_overflow, LAT);
    end
    w = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        w = i;
        break;
      end
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_block = 2'd1;
    @(posedge clk);
    nrsp = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (rsp_valid) nrsp++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    if (rsp_valid) nrsp++;
    rst_n = 1'b1;
    nwr = 0;
    seq_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rsp_valid) nrsp++;
      if (bkt_wr_en) begin
        if (bkt_addr !== D'(nwr) || bkt_wr_data !== '0) seq_ok = 1'b0;
        nwr++;
      end
      @(negedge clk);
    end
    total++;
    if (w == 0 || nrsp != 0) begin
      bad++;
      $display("FAIL midrst_no_rsp: accepted_wait=%0d rsp_pulses=%0d, required accepted and 0 pulses", w, nrsp);
    end
    total++;
    if (nwr != 4 || !seq_ok || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_init: writes=%0d in_order=%b ready=%b, required 4 writes in order ready=1",
               nwr, seq_ok, req_ready);
    end
    do_access(1'b0, 2'd1, 32'h0, h, r, lat, w);
    total++;
    if (lat !== LAT || h !== 1'b0 || r !== 32'h0) begin
      bad++;
      $display("FAIL midrst_read: lat=%0d hit=%b rdata=%h, required lat=%0d hit=0 rdata=0", lat, h, r, LAT);
    end
  endtask

  task automatic test_random();
    logic h; logic [BW-1:0] r; int lat; int w;
    logic [BW-1:0] sb_val [NB];
    bit sb_present [NB];
    int seen [NB];
    logic [D-1:0] b; logic wr; logic [BW-1:0] wd;
    logic [BW-1:0] exp_r; logic exp_h;
    logic [NW-1:0] word; logic [TW-1:0] tup; logic [D-1:0] tblk; logic [LB-1:0] tpos;
    bit inv_ok;
    do_reset();
    for (int i = 0; i < NB; i++) begin
      sb_val[i] = '0;
      sb_present[i] = 1'b0;
    end
    // three blocks never exceed root or leaf capacity, so no overflow is possible
    for (int n = 0; n < 500; n++) begin
      b = D'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_h = sb_present[b];
      exp_q.push_back(sb_present[b] ? sb_val[b] : '0);
      do_access(wr, b, wd, h, r, lat, w);
      exp_r = exp_q.pop_front();
      total++;
      if (lat !== LAT || h !== exp_h || r !== exp_r) begin
        bad++;
        $display("FAIL rand_rsp op=%0d blk=%0d wr=%b: lat=%0d hit=%b rdata=%h, required lat=%0d hit=%b rdata=%h",
                 n, b, wr, lat, h, r, LAT, exp_h, exp_r);
      end
      sb_present[b] = 1'b1;
      if (wr) sb_val[b] = wd;
      else sb_val[b] = exp_r;
      inv_ok = 1'b1;
      for (int i = 0; i < NB; i++) seen[i] = 0;
      for (int a = 0; a < NB; a++) begin
        word = mem[a];
        for (int s = 0; s < K; s++) begin
          tup = word[s*TW +: TW];
          if (tup[TW-1]) begin
            tblk = tup[BW+LB +: D];
            tpos = tup[BW +: LB];
            if (a == 3) inv_ok = 1'b0;
            if (a >= 1 && a <= 2 && int'(tpos) != a - 1) inv_ok = 1'b0;
            seen[tblk]++;
            if (tup[BW-1:0] !== sb_val[tblk]) inv_ok = 1'b0;
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (seen[i] != (sb_present[i] ? 1 : 0)) inv_ok = 1'b0;
      end
      total++;
      if (!inv_ok) begin
        bad++;
        $display("FAIL rand_tree op=%0d: tuples off-path, duplicated, missing or stale; counts b0=%0d b1=%0d b2=%0d b3=%0d",
                 n, seen[0], seen[1], seen[2], seen[3]);
      end
    end
    total++;
    if (conflicts != 0 || err_overflow !== 1'b0) begin
      bad++;
      $display("FAIL rand_port: rd_wr_overlaps=%0d err=%b, required 0 overlaps err=0", conflicts, err_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_miss();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oram_access_ctrl.md
# oram_access_ctrl

Synthesizable sequencer for one tree-ORAM access: position-map lookup, full-path read with removal, remap to a fresh random leaf, root insertion, then a single-path flush. It sits between a client request port and an external single-port bucket RAM holding the binary tree, one bucket per word. Latency is fixed and independent of hit/miss, so access patterns stay oblivious.

## Interface
- BYTE_WIDTH, 8, bits per byte
- BYTES_PER_BLOCK, 4, bytes per block; BW = BYTE_WIDTH*BYTES_PER_BLOCK
- TREE_DEPTH, 2, levels on a root-to-leaf path; must be >= 2; LB = TREE_DEPTH-1 leaf bits
- K, 3, tuples per bucket
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value
- Tuple layout (TW = 1+TREE_DEPTH+LB+BW bits), MSB to LSB: empty_n, b_number[TREE_DEPTH-1:0], pos[LB-1:0], val[BW-1:0]. Slot j = bucket[j*TW +: TW].
- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_block  in  TREE_DEPTH  block number
- req_wdata  in  BW  write data
- rsp_valid  out  1  one-cycle pulse, no backpressure
- rsp_rdata  out  BW  previous block value (0 on miss)
- rsp_hit  out  1  block was found on its path
- bkt_rd_en  out  1  read strobe; data returned next cycle
- bkt_wr_en  out  1  write strobe; never asserted with bkt_rd_en
- bkt_addr  out  TREE_DEPTH  node number minus 1
- bkt_wr_data  out  K*TW  bucket write data
- bkt_rd_data  in  K*TW  bucket read data
- err_overflow  out  1  sticky, root insertion failed

## Operation
- Reset values: all outputs 0; position map (2^TREE_DEPTH entries of {valid, pos}) cleared; LFSR = LFSR_SEED; state INIT.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Advances every cycle after reset. Samples take lfsr[LB-1:0].
- INIT: write all-zero buckets to addresses 0..2^TREE_DEPTH-1, one per cycle. Then IDLE.
- IDLE: req_ready=1. On req_valid, latch request and go to LOOKUP.
- LOOKUP: leaf = posmap entry. If the entry is invalid, leaf = LFSR sample and hit is presumed 0.
- Path, levels l=0..TREE_DEPTH-1: node n starts at 1; descend with n = 2n+leaf[l-1]. Two states per level:
  - PATH_RD: read n-1.
  - PATH_WR: clear every slot with empty_n && b_number==blk && pos==leaf. Capture its val and set hit. Write the bucket back even if unchanged.
- If several slots match, the deepest level's val wins and all matches are cleared.
- New value = req_wdata on a write, else the captured val (0 on a miss).
- ROOT_RD: read address 0. Sample new leaf from the LFSR.
- ROOT_WR:
  - Place the tuple {1, blk, new leaf, value} in the lowest-index empty root slot and set posmap[blk] = {1, new leaf}.
  - If no slot is empty: root is written back unchanged, posmap[blk] is invalidated, and err_overflow is set.
  - Sample pos_star from the LFSR.
- Flush, d=0..TREE_DEPTH-2, along pos_star (parent = level d, child = level d+1), four states per d:
  - FL_RDP: read parent.
  - FL_RDC: read child, capture parent.
  - FL_WRC: eligible parent tuples (valid and pos[d]==pos_star[d]) move, lowest index first, into the lowest empty child slots; write child.
  - FL_WRP: write parent with moved slots cleared.
- DONE: rsp_valid=1, rsp_rdata/rsp_hit driven, then IDLE. rsp_rdata/rsp_hit hold until the next DONE.
- err_overflow clears only on reset.
- Reset asserted mid-operation: abort, no rsp_valid, restart at INIT.

## Timing
- INIT takes 2^TREE_DEPTH cycles. req_ready first rises on the cycle after the last INIT write.
- Acceptance cycle = 0. LOOKUP is cycle 1, the path takes cycles 2..2·TREE_DEPTH+1, and ROOT_RD/ROOT_WR follow. The flush takes 4(TREE_DEPTH-1) cycles. DONE falls at cycle 6·TREE_DEPTH (12 at defaults), for hit, miss and overflow alike.
- Back-to-back: the next request can be accepted the cycle after DONE.
- One RAM operation per cycle. Write data is used in the same cycle as bkt_wr_en.

## Test plan
- Reset then release: 4 zero writes to addresses 0,1,2,3 on consecutive cycles → req_ready=1 in the following cycle; all other outputs 0.
- Write block 2 = 0xDEADBEEF, then read block 2 → rsp_hit=1, rsp_rdata=0xDEADBEEF; each rsp_valid exactly 12 cycles after its acceptance.
- Read of never-written block 1 → rsp_hit=0, rsp_rdata=0. A second read of block 1 → rsp_hit=1, rsp_rdata=0.
- RAM model with all path buckets full of foreign valid tuples whose pos never matches, then write block 3 → err_overflow=1 and stays 1. Later read of block 3 → rsp_hit=0. Latency is still 12.
- 500 random reads/writes against a scoreboard:
  - every read returns the last written value;
  - after each DONE, every valid tuple lies on its leaf's path;
  - valid tuples = valid posmap entries;
  - rd_en and wr_en are never high together.
- Pull rst_n low at cycle 4 of an access → no rsp_valid, INIT rerun (4 writes). A subsequent read of the earlier-written block → rsp_hit=0.
